// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: packs little-endian bytes into 32-bit words,
// writes DEPTH words, then releases cpu_hold_o. Optional checksum byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              cpu_hold_o,
  output logic              err_o
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StRecv, StWrite, StDone, StCheck, StErr} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;
`endif

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [1:0]          byte_q;
  logic [23:0]         part_q;
  logic                in_ready_q, mem_we_q, busy_q, done_q, cpu_hold_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic                restart;
  logic                accept;

  assign accept = in_valid_i & in_ready_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;
  logic       err_q;
  assign restart = start_i & ((state_q == StIdle) | (state_q == StDone) | (state_q == StErr));
  assign err_o   = err_q;
`else
  assign restart = start_i & ((state_q == StIdle) | (state_q == StDone));
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      byte_q      <= '0;
      part_q      <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cpu_hold_q  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else if (restart) begin
      state_q    <= StRecv;
      idx_q      <= '0;
      byte_q     <= '0;
      part_q     <= '0;
      in_ready_q <= 1'b1;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      cpu_hold_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StRecv: begin
          if (accept) begin
            byte_q <= byte_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q  <= xor_q ^ in_data_i;
`endif
            unique case (byte_q)
              2'd0: part_q[7:0]   <= in_data_i;
              2'd1: part_q[15:8]  <= in_data_i;
              2'd2: part_q[23:16] <= in_data_i;
              2'd3: begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= idx_q;
                mem_wdata_q <= {in_data_i, part_q};
                in_ready_q  <= 1'b0;
                state_q     <= StWrite;
              end
              default: ;
            endcase
          end
        end
        StWrite: begin
          mem_we_q <= 1'b0;
          if (idx_q == LastIdx) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            in_ready_q <= 1'b1;
            state_q    <= StCheck;
`else
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
            state_q    <= StDone;
`endif
          end else begin
            idx_q      <= idx_q + ADDR_W'(1);
            in_ready_q <= 1'b1;
            state_q    <= StRecv;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        StCheck: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (in_data_i == xor_q) begin
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
              state_q    <= StDone;
            end else begin
              err_q   <= 1'b1;
              state_q <= StErr;
            end
          end
        end
        StErr: ;
`endif
        StIdle, StDone: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign cpu_hold_o  = cpu_hold_q;

endmodule
